// File: rtl/dram_miss_queue.sv
// dram_miss_queue: buffers cache miss requests and issues them one at a time
// to the SDRAM line controller, returning each fill line via a response register.
module dram_miss_queue #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic         main_clk,
    input  logic         main_rst_n,
    input  logic         miss_valid,
    output logic         miss_ready,
    input  logic [21:0]  miss_addr_read,
    input  logic [10:0]  miss_addr_write_upper,
    input  logic         miss_dirty,
    input  logic [127:0] miss_lane,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [21:0]  resp_addr,
    output logic [127:0] resp_lane,
    output logic [10:0]  addr_req_read_dram_side_dram,
    output logic [10:0]  addr_req_write_dram_side_dram,
    output logic [10:0]  addr_req_common_side_dram,
    output logic [127:0] lane_from_cache_to_dram_side_dram,
    output logic         dram_controller_entry_dirty_side_dram,
    output logic         dram_controller_req_read_pulse_side_dram,
    input  logic         dram_controller_ack_read_pulse_side_dram,
    input  logic [127:0] lane_from_dram_to_cache_side_dram,
    output logic         busy,
    output logic         err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef struct packed {
        logic [21:0]  addr_read;
        logic [10:0]  write_upper;
        logic         dirty;
        logic [127:0] lane;
    } entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [10:0]   rd_addr_q, rd_addr_d;
    logic [10:0]   wr_addr_q, wr_addr_d;
    logic [10:0]   common_q, common_d;
    logic [127:0]  wlane_q, wlane_d;
    logic          dirty_q, dirty_d;
    logic          pulse_q, pulse_d;
    logic          resp_valid_q, resp_valid_d;
    logic [21:0]   resp_addr_q, resp_addr_d;
    logic [127:0]  resp_lane_q, resp_lane_d;
    logic          err_q, err_d;
    logic [15:0]   wd_q, wd_d;
    logic          push, pop;
    entry_t        head;

    assign miss_ready = (count_q != FULL);
    assign busy       = (count_q != '0) || (state_q == WAIT);

    assign resp_valid  = resp_valid_q;
    assign resp_addr   = resp_addr_q;
    assign resp_lane   = resp_lane_q;
    assign err_timeout = err_q;

    assign addr_req_read_dram_side_dram             = rd_addr_q;
    assign addr_req_write_dram_side_dram            = wr_addr_q;
    assign addr_req_common_side_dram                = common_q;
    assign lane_from_cache_to_dram_side_dram        = wlane_q;
    assign dram_controller_entry_dirty_side_dram    = dirty_q;
    assign dram_controller_req_read_pulse_side_dram = pulse_q;

    always_comb begin
        push = miss_valid && miss_ready;
        pop  = (state_q == IDLE) && (count_q != '0) && !resp_valid_q;
        head = mem_q[rd_ptr_q];

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr_read:   miss_addr_read,
                                write_upper: miss_addr_write_upper,
                                dirty:       miss_dirty,
                                lane:        miss_lane};
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        common_d     = common_q;
        wlane_d      = wlane_q;
        dirty_d      = dirty_q;
        pulse_d      = 1'b0;
        wd_d         = wd_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_lane_d  = resp_lane_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    rd_addr_d = head.addr_read[21:11];
                    wr_addr_d = head.write_upper;
                    common_d  = head.addr_read[10:0];
                    wlane_d   = head.lane;
                    dirty_d   = head.dirty;
                    pulse_d   = 1'b1;
                    wd_d      = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (dram_controller_ack_read_pulse_side_dram) begin
                    resp_lane_d  = lane_from_dram_to_cache_side_dram;
                    resp_addr_d  = {rd_addr_q, common_q};
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    // Saturate so a hung controller cannot wrap the watchdog.
                    if (wd_q != 16'hFFFF) begin
                        wd_d = wd_q + 16'd1;
                    end
                    if (wd_d >= TMO) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            common_q     <= '0;
            wlane_q      <= '0;
            dirty_q      <= 1'b0;
            pulse_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_lane_q  <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            common_q     <= common_d;
            wlane_q      <= wlane_d;
            dirty_q      <= dirty_d;
            pulse_q      <= pulse_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_lane_q  <= resp_lane_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
        end
    end

endmodule

// File: tb/tb_dram_miss_queue.sv
// tb_dram_miss_queue: directed scenarios followed by a randomized run checked
// against a queue-based model of the miss/response/controller flow.
module tb_dram_miss_queue;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 15;

    logic         main_clk = 1'b0;
    logic         main_rst_n = 1'b0;
    logic         miss_valid = 1'b0;
    logic         miss_ready;
    logic [21:0]  miss_addr_read = '0;
    logic [10:0]  miss_addr_write_upper = '0;
    logic         miss_dirty = 1'b0;
    logic [127:0] miss_lane = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [21:0]  resp_addr;
    logic [127:0] resp_lane;
    logic [10:0]  rd_addr_o;
    logic [10:0]  wr_addr_o;
    logic [10:0]  common_o;
    logic [127:0] wlane_o;
    logic         dirty_o;
    logic         pulse;
    logic         ack = 1'b0;
    logic [127:0] ack_lane = '0;
    logic         busy;
    logic         err_timeout;

    int tests = 0;
    int fails = 0;

    always #5 main_clk = ~main_clk;

    dram_miss_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .main_clk(main_clk),
        .main_rst_n(main_rst_n),
        .miss_valid(miss_valid),
        .miss_ready(miss_ready),
        .miss_addr_read(miss_addr_read),
        .miss_addr_write_upper(miss_addr_write_upper),
        .miss_dirty(miss_dirty),
        .miss_lane(miss_lane),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_addr(resp_addr),
        .resp_lane(resp_lane),
        .addr_req_read_dram_side_dram(rd_addr_o),
        .addr_req_write_dram_side_dram(wr_addr_o),
        .addr_req_common_side_dram(common_o),
        .lane_from_cache_to_dram_side_dram(wlane_o),
        .dram_controller_entry_dirty_side_dram(dirty_o),
        .dram_controller_req_read_pulse_side_dram(pulse),
        .dram_controller_ack_read_pulse_side_dram(ack),
        .lane_from_dram_to_cache_side_dram(ack_lane),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic [21:0]  a;
        logic [10:0]  wu;
        logic         d;
        logic [127:0] l;
    } req_t;

    typedef struct {
        logic [21:0]  a;
        logic [127:0] l;
    } rsp_t;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic push_miss(input logic [21:0] a, input logic [10:0] wu,
                             input logic d, input logic [127:0] l);
        int n = 0;
        miss_valid = 1'b1;
        miss_addr_read = a;
        miss_addr_write_upper = wu;
        miss_dirty = d;
        miss_lane = l;
        while (!miss_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_wait", 128'(n < 50), 1);
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic send_ack(input logic [127:0] l);
        ack = 1'b1;
        ack_lane = l;
        tick();
        ack = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"}, pulse, 0);
        check({tag, "_rd"}, rd_addr_o, 0);
        check({tag, "_wr"}, wr_addr_o, 0);
        check({tag, "_common"}, common_o, 0);
        check({tag, "_wlane"}, wlane_o, 0);
        check({tag, "_dirty"}, dirty_o, 0);
        check({tag, "_rvalid"}, resp_valid, 0);
        check({tag, "_raddr"}, resp_addr, 0);
        check({tag, "_rlane"}, resp_lane, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, miss_ready, 1);
    endtask

    task automatic check_drive(input string tag, input req_t r);
        check({tag, "_rd"}, rd_addr_o, r.a[21:11]);
        check({tag, "_wr"}, wr_addr_o, r.wu);
        check({tag, "_common"}, common_o, r.a[10:0]);
        check({tag, "_wlane"}, wlane_o, r.l);
        check({tag, "_dirty"}, dirty_o, r.d);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        req_t r3, ra, rb, rc;
        logic [21:0] a5;
        logic [127:0] l3;
        req_t pend[$];
        rsp_t expq[$];
        req_t cur;
        rsp_t rr;
        bit outst;
        bit exp_issue;
        bit rv_pre;
        int cnt;

        // 1: reset state and first issue latency
        repeat (3) @(posedge main_clk);
        #1;
        check_zero("rst");
        main_rst_n = 1'b1;
        tick();
        push_miss(22'h12345, 11'h000, 1'b0, '0);
        check("t1_no_bypass", pulse, 0);
        tick();
        check("t1_pulse", pulse, 1);
        check("t1_common", common_o, 11'h345);
        check("t1_read", rd_addr_o, 11'h024);
        check("t1_dirty", dirty_o, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_pulse_width", pulse, 0);

        // 2: clean fill, ack 14 cycles after the pulse
        repeat (12) tick();
        check("t2_no_resp_yet", resp_valid, 0);
        send_ack({16{8'hA5}});
        check("t2_rvalid", resp_valid, 1);
        check("t2_rlane", resp_lane, {16{8'hA5}});
        check("t2_raddr", resp_addr, 22'h12345);
        consume();
        check("t2_rvalid_clr", resp_valid, 0);
        check("t2_busy", busy, 0);
        check("t2_err", err_timeout, 0);

        // 3: dirty miss, drive registers stable for the whole transaction
        l3 = 128'h0123456789ABCDEF0123456789ABCDEF;
        r3 = '{22'h2ABCD, 11'h7FF, 1'b1, l3};
        push_miss(r3.a, r3.wu, r3.d, r3.l);
        tick();
        check("t3_pulse", pulse, 1);
        repeat (3) tick();
        check_drive("t3_p3", r3);
        repeat (11) tick();
        check("t3_err_p14", err_timeout, 0);
        tick();
        check("t3_err_p15", err_timeout, 1);
        repeat (5) tick();
        check_drive("t3_p20", r3);
        send_ack(~l3);
        check("t3_rlane", resp_lane, ~l3);
        check("t3_raddr", resp_addr, r3.a);
        consume();

        main_rst_n = 1'b0;
        #1;
        check("t3_rst_err", err_timeout, 0);
        main_rst_n = 1'b1;
        tick();

        // 4: backpressure with DEPTH=2 and a stalled response
        ra = '{22'h00ABC, 11'h001, 1'b0, rnd128()};
        rb = '{22'h11DEF, 11'h002, 1'b1, rnd128()};
        rc = '{22'h3F123, 11'h003, 1'b0, rnd128()};
        push_miss(ra.a, ra.wu, ra.d, ra.l);
        push_miss(rb.a, rb.wu, rb.d, rb.l);
        push_miss(rc.a, rc.wu, rc.d, rc.l);
        check("t4_full", miss_ready, 0);
        check_drive("t4_a", ra);
        tick();
        send_ack(128'hA);
        check("t4_a_raddr", resp_addr, ra.a);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_blocked", pulse, 0);
            check("t4_still_full", miss_ready, 0);
        end
        consume();
        check("t4_consumed", resp_valid, 0);
        check("t4_no_issue_same_edge", pulse, 0);
        tick();
        check("t4_b_pulse", pulse, 1);
        check_drive("t4_b", rb);
        check("t4_room", miss_ready, 1);
        send_ack(128'hB);
        check("t4_b_raddr", resp_addr, rb.a);
        check("t4_b_rlane", resp_lane, 128'hB);
        consume();
        tick();
        check("t4_c_pulse", pulse, 1);
        send_ack(128'hC);
        check("t4_c_raddr", resp_addr, rc.a);
        consume();
        check("t4_busy", busy, 0);

        // 5: watchdog expiry and late ack
        a5 = 22'h2468A;
        push_miss(a5, 11'h0F0, 1'b0, '0);
        tick();
        check("t5_pulse", pulse, 1);
        repeat (14) tick();
        check("t5_err_p14", err_timeout, 0);
        tick();
        check("t5_err_p15", err_timeout, 1);
        repeat (24) tick();
        check("t5_sticky", err_timeout, 1);
        check("t5_no_resp", resp_valid, 0);
        send_ack(128'h5);
        check("t5_late_rvalid", resp_valid, 1);
        check("t5_late_raddr", resp_addr, a5);
        check("t5_err_kept", err_timeout, 1);
        consume();

        // 6: reset during WAIT abandons the transaction
        push_miss(22'h13579, 11'h111, 1'b1, rnd128());
        tick();
        check("t6_pulse", pulse, 1);
        repeat (2) tick();
        main_rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        tick();
        main_rst_n = 1'b1;
        repeat (2) tick();
        send_ack(128'h6);
        check("t6_ack_ignored", resp_valid, 0);
        check("t6_busy", busy, 0);
        push_miss(22'h0F0F0, 11'h222, 1'b0, '0);
        tick();
        check("t6_reissue", pulse, 1);
        check("t6_reissue_common", common_o, 11'h0F0);
        send_ack(128'h7);
        check("t6_raddr", resp_addr, 22'h0F0F0);
        consume();

        // randomized traffic against a queue model
        outst = 1'b0;
        cnt = 0;
        cur = '{'0, '0, 1'b0, '0};
        for (int cyc = 0; cyc < 3200; cyc++) begin
            rv_pre = resp_valid;
            exp_issue = !resp_valid && (pend.size() != 0) && !outst;
            if (miss_valid && miss_ready) begin
                pend.push_back('{miss_addr_read, miss_addr_write_upper,
                                 miss_dirty, miss_lane});
            end
            if (resp_valid && resp_ready) begin
                check("rnd_resp_expected", 128'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    rr = expq.pop_front();
                    check("rnd_raddr", resp_addr, rr.a);
                    check("rnd_rlane", resp_lane, rr.l);
                end
            end
            if (ack) begin
                expq.push_back('{cur.a, ack_lane});
                outst = 1'b0;
            end
            tick();
            check("rnd_issue", pulse, exp_issue);
            if (pulse) begin
                check("rnd_issue_block", rv_pre, 0);
                if (pend.size() != 0) begin
                    cur = pend.pop_front();
                    check_drive("rnd_drive", cur);
                end
                outst = 1'b1;
                cnt = $urandom_range(0, 12);
            end
            check("rnd_miss_ready", miss_ready, 128'(pend.size() != DEPTH));
            check("rnd_busy", busy, 128'((pend.size() != 0) || outst));
            if (cyc < 3000) begin
                miss_valid = ($urandom_range(0, 2) != 0);
                resp_ready = ($urandom_range(0, 1) != 0);
            end else begin
                miss_valid = 1'b0;
                resp_ready = 1'b1;
            end
            miss_addr_read = 22'($urandom());
            miss_addr_write_upper = 11'($urandom());
            miss_dirty = 1'($urandom());
            miss_lane = rnd128();
            ack = 1'b0;
            if (outst) begin
                if (cnt == 0) begin
                    ack = 1'b1;
                    ack_lane = rnd128();
                end else begin
                    cnt--;
                end
            end
        end
        check("rnd_drain_pend", 128'(pend.size()), 0);
        check("rnd_drain_resp", 128'(expq.size()), 0);
        check("rnd_drain_busy", busy, 0);
        check("rnd_err", err_timeout, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_miss_queue.md
Name: dram_miss_queue

Overview:
- Sits directly upstream of the SDRAM line controller. Accepts cache-line miss requests (fill address plus optional dirty victim line) from the cache, buffers them in a small FIFO, and issues them one at a time over the controller's pulse handshake.
- Returns each 128-bit fill line to the cache through a valid/ready response register.
- Keeps exactly one DRAM transaction outstanding and holds all controller-facing signals stable for the whole transaction.

Parameters:
DEPTH, 2, request FIFO entries; must be a power of 2, at least 2
TIMEOUT, 1023, cycles in WAIT before err_timeout is raised; range 1..65535

Ports:
main_clk  in  1  single clock; all logic is rising-edge
main_rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  cache presents a miss request
miss_ready  out  1  FIFO can accept; equals (count != DEPTH)
miss_addr_read  in  22  line address to fill
miss_addr_write_upper  in  11  victim address bits [21:11]; victim bits [10:0] equal miss_addr_read[10:0]
miss_dirty  in  1  victim line must be written back
miss_lane  in  128  victim line data
resp_valid  out  1  fill line available
resp_ready  in  1  cache consumes response
resp_addr  out  22  address of returned line
resp_lane  out  128  returned line
addr_req_read_dram_side_dram  out  11  drive register, miss_addr_read[21:11]
addr_req_write_dram_side_dram  out  11  drive register, miss_addr_write_upper
addr_req_common_side_dram  out  11  drive register, miss_addr_read[10:0]
lane_from_cache_to_dram_side_dram  out  128  drive register, victim data
dram_controller_entry_dirty_side_dram  out  1  drive register, dirty flag
dram_controller_req_read_pulse_side_dram  out  1  single-cycle request pulse
dram_controller_ack_read_pulse_side_dram  in  1  single-cycle completion pulse
lane_from_dram_to_cache_side_dram  in  128  fill data; valid in the ack cycle
busy  out  1  FIFO non-empty or state==WAIT
err_timeout  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset (async assert, synchronous deassert is the integrator's job). All registers go to 0: FIFO pointers, count, state=IDLE, every drive register, pulse, resp_valid, resp_addr, resp_lane, err_timeout, watchdog. miss_ready=1 after reset.
- FIFO push happens when miss_valid && miss_ready. An entry is {addr_read, write_upper, dirty, lane}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - There is no bypass: an entry pushed at edge E is poppable at E+1 at the earliest.
  - Simultaneous push and pop: count is unchanged, both actions take effect.
- State IDLE:
  - If count!=0 && !resp_valid, at that edge: pop the head, load all five drive registers from it, set the pulse register to 1, clear the watchdog, and go to WAIT.
  - Otherwise hold. An ack seen in IDLE is ignored.
- State WAIT:
  - The pulse register returns to 0 after exactly one cycle.
  - The drive registers stay unchanged until the next pop. The controller samples write data and the dirty flag several cycles after the pulse, so stability is mandatory.
  - On ack (any WAIT cycle, including the pulse cycle): resp_lane <= lane_from_dram_to_cache_side_dram, resp_addr <= driven read address, resp_valid <= 1, state <= IDLE.
  - With no ack, the watchdog increments (saturating). When it reaches TIMEOUT, err_timeout <= 1 and the block stays in WAIT; there is no retry, and a late ack still completes normally.
- Response: resp_valid clears on the edge where resp_valid && resp_ready. The next issue can pop at that same edge only if resp_valid was already 0, so issue is blocked for the whole cycle resp_valid==1.
- Minimum spacing: the ack edge returns the block to IDLE, so the next pulse is at least 2 cycles after the ack. A pulse never coincides with an ack.
- Latency:
  - Miss accepted at E0 → pulse visible after E1 (FIFO empty, resp free).
  - Ack at edge En → resp_valid high after En.
- Reset during WAIT: the outstanding transaction is abandoned, and any later ack lands in IDLE and is ignored.
- Full FIFO: miss_ready=0. A pop that same cycle does not make room until the next cycle.

Test Plan:
1. Reset → all outputs 0, miss_ready=1, busy=0; push miss_addr_read=22'h12345, dirty=0 at E0 → pulse high one cycle after E1, addr_req_common=11'h345, addr_req_read=11'h024, entry_dirty=0.
2. Clean fill: model ack 14 cycles after pulse with lane=128'hA5…A5 → resp_valid=1, resp_lane=A5…A5, resp_addr=22'h12345; resp_ready=1 → resp_valid=0 next cycle, busy=0.
3. Dirty miss: dirty=1, write_upper=11'h7FF, lane=128'h0123…CDEF → drive registers hold identical values every cycle from pulse to ack (checked at pulse+3 and pulse+20).
4. Backpressure (DEPTH=2): push 3 misses while resp_ready=0 → the first issues; the next two fill the FIFO, miss_ready=0. The second pulse does not fire until the first response is consumed; 3 responses are returned in order.
5. Timeout (TIMEOUT=15): no ack → err_timeout=1 after 15 WAIT cycles, sticky. A late ack at cycle 40 still yields resp_valid=1; err_timeout stays 1.
6. Reset mid-WAIT → all outputs 0; an ack pulse 3 cycles after release produces no response, and the next miss issues normally.
